// File: rtl/cram_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : cram_loader_if
// Brief    : Bitstream word handshake between the bitstream source and the
//            CRAM configuration loader.
// Revision : 1.0 - initial release
// ============================================================================
interface cram_loader_if #(
    parameter int WORD_W = 16
);
    logic [2*WORD_W-1:0] bs_data;
    logic                bs_valid;
    logic                bs_ready;

    modport master (
        output bs_data,
        output bs_valid,
        input  bs_ready
    );

    modport slave (
        input  bs_data,
        input  bs_valid,
        output bs_ready
    );
endinterface
`default_nettype wire

// File: rtl/cram_loader.sv
`default_nettype none
// ============================================================================
// Module   : cram_loader
// Brief    : Serializes 32-bit bitstream words onto the two CB CRAM shift
//            chains (banks A/B) and checks the chain tails for stuck zeros.
// Revision : 1.0 - initial release
// ============================================================================
module cram_loader #(
    parameter int CHAIN_LEN = 30,
    parameter int WORD_W    = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         start,
    input  logic         check_ones,
    cram_loader_if.slave bs,
    output logic         config_en,
    output logic         config_data_outA,
    output logic         config_data_outB,
    input  logic         config_data_inA,
    input  logic         config_data_inB,
    output logic         busy,
    output logic         done,
    output logic         chain_err
);

    localparam int c_REM_W = $clog2(CHAIN_LEN + 1);
    localparam int c_WC_W  = $clog2(WORD_W + 1);

    localparam logic [c_REM_W-1:0] c_CHAIN_LEN = c_REM_W'(CHAIN_LEN);
    localparam logic [c_WC_W-1:0]  c_WORD_CNT  = c_WC_W'(WORD_W);
    localparam logic [c_REM_W-1:0] c_REM_ONE   = c_REM_W'(1);
    localparam logic [c_WC_W-1:0]  c_WC_ONE    = c_WC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_sh_a;
    logic [WORD_W-1:0]   r_sh_b;
    logic [c_REM_W-1:0]  r_rem;
    logic [c_WC_W-1:0]   r_wcnt;
    logic                r_check;
    logic                r_err;
    logic [c_WC_W-1:0]   w_take;

    // Bits to take from the next word: a full word, or what is left of the chain
    always_comb begin
        if (32'(r_rem) < 32'(WORD_W)) begin
            w_take = c_WC_W'(r_rem);
        end else begin
            w_take = c_WORD_CNT;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bs.bs_valid) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_wcnt <= c_WC_ONE) begin
                    w_state_nxt = (r_rem <= c_REM_ONE) ? S_DONE : S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_rem   <= '0;
            r_wcnt  <= '0;
            r_check <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_check <= check_ones;
                        r_rem   <= c_CHAIN_LEN;
                        r_err   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (bs.bs_valid) begin
                        r_sh_a <= bs.bs_data[WORD_W-1:0];
                        r_sh_b <= bs.bs_data[2*WORD_W-1:WORD_W];
                        r_wcnt <= w_take;
                    end
                end
                S_SHIFT: begin
                    r_sh_a <= {r_sh_a[WORD_W-2:0], 1'b0};
                    r_sh_b <= {r_sh_b[WORD_W-2:0], 1'b0};
                    if (r_rem != '0) begin
                        r_rem <= r_rem - c_REM_ONE;
                    end
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - c_WC_ONE;
                    end
                    // Tails still carry reset ones while the new data travels the chain
                    if (r_check && !(config_data_inA && config_data_inB)) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bs.bs_ready       = (r_state == S_FETCH);
    assign config_en         = (r_state == S_SHIFT);
    assign config_data_outA  = (r_state == S_SHIFT) & r_sh_a[WORD_W-1];
    assign config_data_outB  = (r_state == S_SHIFT) & r_sh_b[WORD_W-1];
    assign busy              = (r_state != S_IDLE);
    assign done              = (r_state == S_DONE);
    assign chain_err         = r_err;

endmodule
`default_nettype wire
